// File: rtl/mem_scan_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_scan_checker_pkg
//  Description : Shared state encoding, default sizes and a width helper for
//                the end-of-run memory scan checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_scan_checker_pkg;

  // Default sizes, matching the MIPS32 core data RAM (RAM_SIZE/4 words).
  localparam int c_def_data_w  = 32;
  localparam int c_def_depth   = 2048;
  localparam int c_def_addr_w  = 11;
  localparam int c_def_rd_lat  = 1;
  localparam int c_def_timeout = 34300;
  localparam int c_def_cnt_w   = 16;

  // Checker session states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while (w < 31 && (1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_scan_checker_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_scan_checker_pipe
//  Description : RD_LAT-deep valid/address delay line that lines up each read
//                address with the data returned by the memory ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_scan_checker_pipe
  import mem_scan_checker_pkg::*;
#(
  parameter int ADDR_W = c_def_addr_w,
  parameter int RD_LAT = c_def_rd_lat
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              cmp_valid,
  output logic [ADDR_W-1:0] cmp_addr,
  output logic              pending
);

  logic [RD_LAT-1:0] r_valid;
  logic [ADDR_W-1:0] r_addr [RD_LAT];

  // Shift the read strobe and its address one stage per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) r_addr[i] <= '0;
    end else if (clr) begin
      r_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) r_addr[i] <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_addr[0]  <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign cmp_valid = r_valid[RD_LAT-1];
  assign cmp_addr  = r_addr[RD_LAT-1];

  // Reads still in flight after the current compare; the last stage is
  // consumed this cycle so it does not hold the drain open.
  if (RD_LAT == 1) begin : g_pend_none
    assign pending = 1'b0;
  end else begin : g_pend_stages
    assign pending = |r_valid[RD_LAT-2:0];
  end

endmodule
`default_nettype wire

// File: rtl/mem_scan_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mem_scan_checker
//  Description : End-of-run data-RAM checker. Waits for CPU halt (or a cycle
//                timeout), walks every word through a read port, compares it
//                with a golden image and reports pass/fail, a saturating
//                error count and the first mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_scan_checker
  import mem_scan_checker_pkg::*;
#(
  parameter int DATA_W        = c_def_data_w,
  parameter int DEPTH         = c_def_depth,
  parameter int ADDR_W        = c_def_addr_w,
  parameter int RD_LAT        = c_def_rd_lat,
  parameter int TIMEOUT       = c_def_timeout,
  parameter int STOP_ON_FIRST = 0,
  parameter int CNT_W         = c_def_cnt_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              halt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] dut_data,
  input  logic [DATA_W-1:0] gold_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam int                  c_tcnt_w    = cnt_width(TIMEOUT);
  localparam logic [ADDR_W-1:0]   c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [c_tcnt_w-1:0] c_tlimit    = c_tcnt_w'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    c_cnt_max   = '1;

  state_t              r_state;
  state_t              w_next;
  logic [c_tcnt_w-1:0] r_tcnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_timed_out;
  logic [CNT_W-1:0]    r_err_count;
  logic [ADDR_W-1:0]   r_first_addr;
  logic [DATA_W-1:0]   r_first_got;
  logic [DATA_W-1:0]   r_first_exp;

  logic                w_start;
  logic                w_tmo_fire;
  logic                w_last;
  logic                w_cmp_valid;
  logic [ADDR_W-1:0]   w_cmp_addr;
  logic                w_pending;
  logic                w_mismatch;

  // A session starts only from IDLE or DONE; arm is ignored while busy.
  assign w_start    = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Timeout fires on the TIMEOUT-th WAIT cycle unless halt is seen then.
  assign w_tmo_fire = (TIMEOUT != 0) && (r_state == S_WAIT) && !halt &&
                      (r_tcnt == c_tlimit);
  assign w_last     = (r_addr == c_last_addr);
  // Case-inequality so X/Z on either port shows up as a mismatch.
  assign w_mismatch = w_cmp_valid && (dut_data !== gold_data);

  mem_scan_checker_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_start),
    .in_valid  (rd_en),
    .in_addr   (r_addr),
    .cmp_valid (w_cmp_valid),
    .cmp_addr  (w_cmp_addr),
    .pending   (w_pending)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic for the check session.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (arm) w_next = S_WAIT;
      S_WAIT:  if (halt || w_tmo_fire) w_next = S_SCAN;
      S_SCAN:  if (w_last || ((STOP_ON_FIRST != 0) && w_mismatch)) w_next = S_DRAIN;
      S_DRAIN: if (!w_pending) w_next = S_DONE;
      S_DONE:  if (arm) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // WAIT-cycle counter and timeout flag, both cleared when a session starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt      <= '0;
      r_timed_out <= 1'b0;
    end else if (w_start) begin
      r_tcnt      <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if ((TIMEOUT != 0) && (r_state == S_WAIT) && !w_tmo_fire)
        r_tcnt <= r_tcnt + c_tcnt_w'(1);
      if (w_tmo_fire)
        r_timed_out <= 1'b1;
    end
  end

  // Read address walks 0..DEPTH-1, one word per SCAN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_addr <= '0;
    else if (w_start)                        r_addr <= '0;
    else if ((r_state == S_SCAN) && !w_last) r_addr <= r_addr + ADDR_W'(1);
  end

  // Error count saturates; first-mismatch details latch once per session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count  <= '0;
      r_first_addr <= '0;
      r_first_got  <= '0;
      r_first_exp  <= '0;
    end else if (w_start) begin
      r_err_count  <= '0;
      r_first_addr <= '0;
      r_first_got  <= '0;
      r_first_exp  <= '0;
    end else if (w_mismatch) begin
      if (r_err_count == '0) begin
        r_first_addr <= w_cmp_addr;
        r_first_got  <= dut_data;
        r_first_exp  <= gold_data;
      end
      if (r_err_count != c_cnt_max)
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign rd_en          = (r_state == S_SCAN);
  assign rd_addr        = r_addr;
  assign busy           = (r_state == S_WAIT) || (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err_count == '0) && !r_timed_out;
  assign timed_out      = r_timed_out;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_addr;
  assign first_err_got  = r_first_got;
  assign first_err_exp  = r_first_exp;

endmodule
`default_nettype wire

// File: tb/tb_mem_scan_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_scan_checker
//  Description : Self-checking bench for mem_scan_checker. Three checker
//                instances (different latency, stop mode and counter width)
//                share one pair of memory images; results are compared with
//                a word-by-word reference computed from the images.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_scan_checker;

  localparam int NI  = 3;
  localparam int AW  = 6;
  localparam int TMO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, arm, halt;
  logic [31:0] dmem [64];
  logic [31:0] gmem [64];

  logic [NI-1:0] rd_en, busy, done, pass, tmo;
  logic [AW-1:0] rd_addr [NI];
  logic [31:0]   dd      [NI];
  logic [31:0]   gd      [NI];
  logic [AW-1:0] fe_addr [NI];
  logic [31:0]   fe_got  [NI];
  logic [31:0]   fe_exp  [NI];
  logic [15:0]   errc0, errc2;
  logic [1:0]    errc1;
  logic [15:0]   errc    [NI];

  assign errc[0] = errc0;
  assign errc[1] = {14'd0, errc1};
  assign errc[2] = errc2;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance parameters, mirrored for the reference model.
  function automatic int p_depth(input int k); return (k == 1) ? 37 : 40; endfunction
  function automatic int p_lat  (input int k); return (k == 0) ? 1 : 3;   endfunction
  function automatic bit p_stop (input int k); return (k == 1);           endfunction
  function automatic int p_cmax (input int k); return (k == 1) ? 3 : 65535; endfunction

  mem_scan_checker #(.DATA_W(32), .DEPTH(40), .ADDR_W(AW), .RD_LAT(1), .TIMEOUT(TMO),
                     .STOP_ON_FIRST(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm), .halt(halt), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .dut_data(dd[0]), .gold_data(gd[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .timed_out(tmo[0]), .err_count(errc0), .first_err_addr(fe_addr[0]),
    .first_err_got(fe_got[0]), .first_err_exp(fe_exp[0]));

  mem_scan_checker #(.DATA_W(32), .DEPTH(37), .ADDR_W(AW), .RD_LAT(3), .TIMEOUT(TMO),
                     .STOP_ON_FIRST(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .arm(arm), .halt(halt), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .dut_data(dd[1]), .gold_data(gd[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .timed_out(tmo[1]), .err_count(errc1), .first_err_addr(fe_addr[1]),
    .first_err_got(fe_got[1]), .first_err_exp(fe_exp[1]));

  mem_scan_checker #(.DATA_W(32), .DEPTH(40), .ADDR_W(AW), .RD_LAT(3), .TIMEOUT(TMO),
                     .STOP_ON_FIRST(0), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .arm(arm), .halt(halt), .rd_en(rd_en[2]), .rd_addr(rd_addr[2]),
    .dut_data(dd[2]), .gold_data(gd[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .timed_out(tmo[2]), .err_count(errc2), .first_err_addr(fe_addr[2]),
    .first_err_got(fe_got[2]), .first_err_exp(fe_exp[2]));

  // Memory ports with the instance's read latency.
  for (genvar k = 0; k < NI; k++) begin : g_mem
    localparam int L = (k == 0) ? 1 : 3;
    logic [AW-1:0] ap [L];
    always @(posedge clk) begin
      ap[0] <= rd_addr[k];
      for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
    end
    assign dd[k] = dmem[ap[L-1]];
    assign gd[k] = gmem[ap[L-1]];
  end

  // Read monitor: number of reads issued and highest address read.
  logic mon_clr;
  int   rcnt [NI];
  int   maxa [NI];
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mon_clr) begin
        rcnt[k] <= 0;
        maxa[k] <= -1;
      end else if (rd_en[k]) begin
        rcnt[k] <= rcnt[k] + 1;
        if (int'(rd_addr[k]) > maxa[k]) maxa[k] <= int'(rd_addr[k]);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_same();
    for (int i = 0; i < 64; i++) begin
      gmem[i] = $urandom;
      dmem[i] = gmem[i];
    end
  endtask

  task automatic flip(input int a);
    dmem[a] = gmem[a] ^ ($urandom | 32'h1);
  endtask

  // Reference: what a scan of instance k should report for the current images.
  task automatic model(input int k, output int e_err, output int e_first, output int e_last,
                       output logic [31:0] e_got, output logic [31:0] e_exp);
    int d, f, cnt;
    d = p_depth(k);
    f = -1;
    for (int i = 0; i < d; i++)
      if (dmem[i] != gmem[i] && f < 0) f = i;
    e_last = d - 1;
    if (p_stop(k) && f >= 0 && f + p_lat(k) < d - 1) e_last = f + p_lat(k);
    cnt = 0;
    for (int i = 0; i <= e_last; i++)
      if (dmem[i] != gmem[i]) cnt++;
    e_err   = (cnt > p_cmax(k)) ? p_cmax(k) : cnt;
    e_first = (f < 0) ? 0 : f;
    e_got   = (f < 0) ? 32'h0 : dmem[f];
    e_exp   = (f < 0) ? 32'h0 : gmem[f];
  endtask

  // One session: arm, raise halt after halt_after WAIT cycles (-1 = never),
  // optionally re-pulse arm mid-scan, then check every instance.
  task automatic run(input int halt_after, input bit poke);
    int n, fr, h, e_err, e_first, e_last, exp_dt, got_dt;
    int dt [NI];
    bit all_done, e_tmo;
    logic [31:0] eg, ee;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    for (int k = 0; k < NI; k++) dt[k] = -1;
    fr = -1;
    n = 0;
    all_done = 1'b0;
    arm = 1'b1;
    while (!all_done && n < 1000) begin
      tick();
      n++;
      arm = poke && (halt_after >= 0) && (n == halt_after + 3);
      if (halt_after >= 0 && n == halt_after) halt = 1'b1;
      if (rd_en[0] && fr < 0) fr = n;
      all_done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (done[k] && dt[k] < 0) dt[k] = n;
        if (dt[k] < 0) all_done = 1'b0;
      end
    end
    halt = 1'b0;
    arm  = 1'b0;
    if (!all_done) check("done_within_budget", 64'd0, 64'd1);
    e_tmo = !(halt_after >= 0 && halt_after <= TMO);
    h     = e_tmo ? TMO : halt_after;
    check("u0 scan_start_cycle", fr, h + 1);
    for (int k = 0; k < NI; k++) begin
      model(k, e_err, e_first, e_last, eg, ee);
      check($sformatf("u%0d err_count", k), errc[k], e_err);
      check($sformatf("u%0d first_err_addr", k), fe_addr[k], e_first);
      check($sformatf("u%0d first_err_got", k), fe_got[k], eg);
      check($sformatf("u%0d first_err_exp", k), fe_exp[k], ee);
      check($sformatf("u%0d timed_out", k), tmo[k], e_tmo);
      check($sformatf("u%0d pass", k), pass[k], (e_err == 0) && !e_tmo);
      check($sformatf("u%0d busy_after_done", k), busy[k], 1'b0);
      check($sformatf("u%0d reads_issued", k), rcnt[k], e_last + 1);
      check($sformatf("u%0d max_rd_addr", k), maxa[k], e_last);
      exp_dt = h + e_last + p_lat(k) + 2;
      got_dt = (dt[k] >= exp_dt - 1 && dt[k] <= exp_dt + 1) ? exp_dt : dt[k];
      check($sformatf("u%0d done_cycle", k), got_dt, exp_dt);
    end
  endtask

  task automatic check_cleared(input string when);
    check({when, " ctrl_bits"}, {rd_en, busy, done, pass, tmo}, 64'd0);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s u%0d err_count", when, k), errc[k], 64'd0);
      check($sformatf("%s u%0d rd_addr", when, k), rd_addr[k], 64'd0);
      check($sformatf("%s u%0d first_err", k == 0 ? when : when, k),
            {fe_addr[k], fe_got[k]} | {32'd0, fe_exp[k]}, 64'd0);
    end
  endtask

  task automatic reset_mid_scan();
    int n;
    fill_same();
    flip(2);
    flip(4);
    arm = 1'b1;
    tick();
    arm  = 1'b0;
    halt = 1'b1;
    n = 0;
    while (!(rd_en[0] && rd_addr[0] == AW'(20)) && n < 200) begin
      tick();
      n++;
    end
    check("reached_scan_addr_20", n < 200, 1'b1);
    #2 rst = 1'b1;
    #1 check_cleared("async_rst");
    halt = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_cleared("after_rst");
  endtask

  initial begin
    int nf;
    rst     = 1'b1;
    arm     = 1'b0;
    halt    = 1'b0;
    mon_clr = 1'b1;
    fill_same();
    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b0;
    tick();

    // Identical images, halt on WAIT cycle 20.
    fill_same();
    run(20, 1'b0);

    // Single corrupted word.
    fill_same();
    dmem[5] = 32'hDEADBEEF;
    gmem[5] = 32'h0;
    run(20, 1'b0);

    // Three differing words; arm re-pulsed mid-scan must be ignored.
    fill_same();
    flip(3); flip(7); flip(9);
    run(20, 1'b1);

    // Four adjacent errors: saturates the 2-bit counter on the stop-on-first unit.
    fill_same();
    flip(10); flip(11); flip(12); flip(13);
    run(8, 1'b0);

    // Boundary words: first and last of each scan range.
    fill_same();
    flip(0); flip(36); flip(39);
    run(1, 1'b0);

    // Halt never comes: forced scan after TIMEOUT WAIT cycles.
    fill_same();
    run(-1, 1'b0);

    // Halt on the same cycle the timeout would fire: halt wins.
    fill_same();
    run(TMO, 1'b0);

    // Reset in the middle of a scan, then a full rescan.
    reset_mid_scan();
    fill_same();
    flip(6); flip(30);
    run(15, 1'b0);

    // Randomised images and halt timing.
    for (int r = 0; r < 6; r++) begin
      fill_same();
      nf = $urandom_range(0, 6);
      for (int j = 0; j < nf; j++) flip($urandom_range(0, 39));
      run($urandom_range(1, 60), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
